// File: rtl/buslogic_cycle.sv
// rtl/buslogic_cycle.sv - 68030 bus-cycle controller: lane strobes, wait states, DSACK/BERR termination
module buslogic_cycle #(
    parameter int PORT_BYTES     = 4,
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_address_strobe,
    input  logic                  cpu_rw,
    input  logic [1:0]            cpu_siz,
    input  logic [1:0]            cpu_addr,
    input  logic                  ext_select,
    input  logic                  ext_ack_n,
    output logic [PORT_BYTES-1:0] data_strobe_n,
    output logic                  strobe_oe,
    output logic [1:0]            dsack_n,
    output logic                  dsack_oe,
    output logic                  berr_n,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // DSACK1/DSACK0 pattern that tells the CPU the port width
    localparam logic [1:0] DSACK_PORT = (PORT_BYTES == 4) ? 2'b00 :
                                        (PORT_BYTES == 2) ? 2'b01 : 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_ACK,
        ST_BERR
    } state_t;

    state_t          state_q, state_d;
    logic            rw_q, rw_d;
    logic [1:0]      siz_q, siz_d;
    logic [1:0]      addr_q, addr_d;
    logic            ext_q, ext_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [PORT_BYTES-1:0] lane_on;
    logic [2:0]            lane_off;
    logic [2:0]            lane_end;
    logic                  tmo_hit;
    logic                  wait_done;

    assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign wait_done = (wait_cnt_q == 4'(WAIT_STATES - 1));

    // Lane decode from latched SIZ/A[1:0]; lane 0 (D31:24) sits in the MSB of the strobe vector
    always_comb begin
        lane_on  = '0;
        lane_off = 3'd0;
        if (PORT_BYTES == 4) begin
            lane_off = {1'b0, addr_q};
        end else if (PORT_BYTES == 2) begin
            lane_off = {2'b00, addr_q[0]};
        end
        // SIZ=00 encodes a long transfer of four bytes
        lane_end = lane_off + ((siz_q == 2'b00) ? 3'd4 : {1'b0, siz_q});
        for (int i = 0; i < PORT_BYTES; i++) begin
            lane_on[PORT_BYTES-1-i] = (3'(i) >= lane_off) && (3'(i) < lane_end);
        end
    end

    // Next-state, latching and counter updates; AS negation overrides everything
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        siz_d      = siz_q;
        addr_d     = addr_q;
        ext_d      = ext_q;
        wait_cnt_d = wait_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        if (state_q != ST_IDLE && cpu_address_strobe) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cpu_address_strobe) begin
                        state_d    = ST_STROBE;
                        rw_d       = cpu_rw;
                        siz_d      = cpu_siz;
                        addr_d     = cpu_addr;
                        ext_d      = ext_select;
                        wait_cnt_d = '0;
                        tmo_cnt_d  = '0;
                    end
                end
                ST_STROBE: begin
                    tmo_cnt_d  = tmo_cnt_q + TW'(1);
                    wait_cnt_d = '0;
                    if (tmo_hit) begin
                        state_d = ST_BERR;
                    end else if (!ext_q && WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    if (ext_q) begin
                        // acknowledge beats a timeout landing on the same edge
                        if (!ext_ack_n) begin
                            state_d = ST_ACK;
                        end else if (tmo_hit) begin
                            state_d = ST_BERR;
                        end
                    end else begin
                        if (wait_done) begin
                            state_d = ST_ACK;
                        end else if (tmo_hit) begin
                            state_d = ST_BERR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 4'd1;
                        end
                    end
                end
                ST_ACK:  state_d = ST_ACK;
                ST_BERR: state_d = ST_BERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Moore outputs: pin values and drive enables from the current state
    always_comb begin
        data_strobe_n = '1;
        strobe_oe     = 1'b0;
        dsack_n       = 2'b11;
        dsack_oe      = 1'b0;
        berr_n        = 1'b1;
        busy          = 1'b0;
        case (state_q)
            ST_STROBE: begin
                strobe_oe = 1'b1;
                busy      = 1'b1;
                // writes hold strobes off for one cycle of data setup
                if (rw_q) begin
                    data_strobe_n = ~lane_on;
                end
            end
            ST_WAIT: begin
                strobe_oe     = 1'b1;
                busy          = 1'b1;
                data_strobe_n = ~lane_on;
            end
            ST_ACK: begin
                strobe_oe     = 1'b1;
                busy          = 1'b1;
                data_strobe_n = ~lane_on;
                dsack_n       = DSACK_PORT;
                dsack_oe      = 1'b1;
            end
            ST_BERR: begin
                strobe_oe = 1'b1;
                busy      = 1'b1;
                dsack_oe  = 1'b1;
                berr_n    = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // State and latched-cycle registers with asynchronous reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            siz_q      <= 2'b00;
            addr_q     <= 2'b00;
            ext_q      <= 1'b0;
            wait_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            siz_q      <= siz_d;
            addr_q     <= addr_d;
            ext_q      <= ext_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_buslogic_cycle.sv
// tb/tb_buslogic_cycle.sv - randomized self-checking bench for buslogic_cycle
module tb_buslogic_cycle;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_address_strobe;
    logic       cpu_rw;
    logic [1:0] cpu_siz;
    logic [1:0] cpu_addr;
    logic       ext_select;
    logic       ext_ack_n;

    logic [3:0] dsn_a;
    logic       soe_a, dsoe_a, berr_a, busy_a;
    logic [1:0] dsk_a;
    logic [1:0] dsn_b;
    logic       soe_b, dsoe_b, berr_b, busy_b;
    logic [1:0] dsk_b;

    int total = 0;
    int bad   = 0;

    localparam int PB_A = 4, WS_A = 1, TO_A = 64;
    localparam int PB_B = 2, WS_B = 0, TO_B = 8;

    always #5 clock = ~clock;

    buslogic_cycle #(.PORT_BYTES(PB_A), .WAIT_STATES(WS_A), .TIMEOUT_CYCLES(TO_A)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .cpu_address_strobe(cpu_address_strobe),
        .cpu_rw(cpu_rw), .cpu_siz(cpu_siz), .cpu_addr(cpu_addr),
        .ext_select(ext_select), .ext_ack_n(ext_ack_n),
        .data_strobe_n(dsn_a), .strobe_oe(soe_a), .dsack_n(dsk_a),
        .dsack_oe(dsoe_a), .berr_n(berr_a), .busy(busy_a)
    );

    buslogic_cycle #(.PORT_BYTES(PB_B), .WAIT_STATES(WS_B), .TIMEOUT_CYCLES(TO_B)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .cpu_address_strobe(cpu_address_strobe),
        .cpu_rw(cpu_rw), .cpu_siz(cpu_siz), .cpu_addr(cpu_addr),
        .ext_select(ext_select), .ext_ack_n(ext_ack_n),
        .data_strobe_n(dsn_b), .strobe_oe(soe_b), .dsack_n(dsk_b),
        .dsack_oe(dsoe_b), .berr_n(berr_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {strobes(4), strobe_oe, dsack_n(2), dsack_oe, berr_n, busy} after edge E0+k
    function automatic logic [9:0] model(input int pb, input int ws, input int to,
                                         input bit rw, input bit [1:0] siz, input bit [1:0] addr,
                                         input bit ext, input int ack_start, input int k, input int rel);
        int         off, n, hi, ack_e;
        logic [3:0] all1, lanes, strb;
        logic [1:0] enc;
        all1  = 4'((1 << pb) - 1);
        off   = addr % pb;
        n     = (siz == 2'b00) ? 4 : int'(siz);
        hi    = (off + n < pb) ? off + n : pb;
        lanes = all1;
        for (int i = off; i < hi; i++) lanes[pb-1-i] = 1'b0;
        enc   = (pb == 4) ? 2'b00 : (pb == 2) ? 2'b01 : 2'b10;
        ack_e = ext ? ((ack_start > 2) ? ack_start : 2) : 1 + ws;
        strb  = (rw || k >= 1) ? lanes : all1;
        if (k >= rel)                    return {all1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
        if (ack_e <= k && ack_e <= to)   return {strb, 1'b1, enc,   1'b1, 1'b1, 1'b1};
        if (to <= k)                     return {all1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1};
        return {strb, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
    endfunction

    function automatic logic [9:0] obs_a();
        return {dsn_a, soe_a, dsk_a, dsoe_a, berr_a, busy_a};
    endfunction

    function automatic logic [9:0] obs_b();
        return {2'b00, dsn_b, soe_b, dsk_b, dsoe_b, berr_b, busy_b};
    endfunction

    task automatic check_both(input string tag, input bit rw, input bit [1:0] siz, input bit [1:0] addr,
                              input bit ext, input int ack_start, input int k, input int rel);
        check_eq($sformatf("%s a k=%0d", tag, k), 32'(obs_a()),
                 32'(model(PB_A, WS_A, TO_A, rw, siz, addr, ext, ack_start, k, rel)));
        check_eq($sformatf("%s b k=%0d", tag, k), 32'(obs_b()),
                 32'(model(PB_B, WS_B, TO_B, rw, siz, addr, ext, ack_start, k, rel)));
    endtask

    // One bus cycle starting at a falling edge; AS held low for as_len sampling edges
    task automatic run_txn(input string tag, input bit rw, input bit [1:0] siz, input bit [1:0] addr,
                           input bit ext, input int ack_start, input int as_len);
        cpu_address_strobe = 1'b0;
        cpu_rw     = rw;
        cpu_siz    = siz;
        cpu_addr   = addr;
        ext_select = ext;
        ext_ack_n  = 1'b1;
        for (int k = 0; k < as_len; k++) begin
            @(posedge clock); #1;
            check_both(tag, rw, siz, addr, ext, ack_start, k, as_len);
            @(negedge clock);
            cpu_rw     = 1'($urandom);
            cpu_siz    = 2'($urandom);
            cpu_addr   = 2'($urandom);
            ext_select = 1'($urandom);
            ext_ack_n  = (k + 1 >= ack_start) ? 1'b0 : 1'b1;
            if (k == as_len - 1) cpu_address_strobe = 1'b1;
        end
        @(posedge clock); #1;
        check_both(tag, rw, siz, addr, ext, ack_start, as_len, as_len);
        @(negedge clock);
        ext_ack_n = 1'b1;
    endtask

    initial begin
        reset_n            = 1'b0;
        cpu_address_strobe = 1'b1;
        cpu_rw             = 1'b1;
        cpu_siz            = 2'b00;
        cpu_addr           = 2'b00;
        ext_select         = 1'b0;
        ext_ack_n          = 1'b1;
        #1;
        check_both("reset", 1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_txn("rd_long",   1'b1, 2'b00, 2'b00, 1'b0, 1000, 4);
        run_txn("wr_word",   1'b0, 2'b10, 2'b01, 1'b0, 1000, 4);
        run_txn("wr_3byte",  1'b0, 2'b11, 2'b10, 1'b0, 1000, 4);
        run_txn("rd_byte",   1'b1, 2'b01, 2'b01, 1'b0, 1000, 3);
        run_txn("ext_ack",   1'b1, 2'b00, 2'b00, 1'b1, 6, 10);
        run_txn("ext_berr",  1'b1, 2'b00, 2'b00, 1'b1, 1000, 70);
        run_txn("ack_at_to", 1'b0, 2'b10, 2'b10, 1'b1, 8, 11);
        run_txn("abort",     1'b1, 2'b00, 2'b00, 1'b1, 1000, 3);
        run_txn("b2b_1",     1'b0, 2'b01, 2'b11, 1'b0, 1000, 4);
        run_txn("b2b_2",     1'b0, 2'b01, 2'b11, 1'b0, 1000, 4);

        // Reset pulsed while both instances sit in ACK
        cpu_address_strobe = 1'b0;
        cpu_rw     = 1'b1;
        cpu_siz    = 2'b00;
        cpu_addr   = 2'b00;
        ext_select = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check_both("pre_rst", 1'b1, 2'b00, 2'b00, 1'b0, 1000, k, 100);
        end
        #1 reset_n = 1'b0;
        #1;
        check_both("mid_rst", 1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        @(negedge clock);
        cpu_address_strobe = 1'b1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_both("post_rst", 1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        @(negedge clock);

        for (int t = 0; t < 40; t++) begin
            bit       rw, ext;
            bit [1:0] siz, addr;
            int       ack_start, as_len;
            rw        = 1'($urandom);
            ext       = 1'($urandom);
            siz       = 2'($urandom);
            addr      = 2'($urandom);
            ack_start = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, 12));
            as_len    = int'($urandom_range(1, 14));
            run_txn($sformatf("rnd%0d", t), rw, siz, addr, ext, ack_start, as_len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
